// File: rtl/uart_tx.sv
// uart_tx: 8N1 byte-serial UART transmitter with a small transmit FIFO.
// Ports:
//   clk, reset       block clock, asynchronous active-high reset
//   tx_data, tx_wr   byte to enqueue and its write strobe
//   tx_ovf_clr       clears the sticky overflow flag
//   tx_full/empty    FIFO occupancy flags (registered)
//   tx_busy          a frame is on the line (registered)
//   tx_ovf           sticky: a write arrived while the FIFO was full
//   tx_count         current FIFO occupancy
//   txd              serial output, LSB first, idles high (registered)
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         tx_data,
  input  logic               tx_wr,
  output logic               tx_full,
  output logic               tx_empty,
  output logic               tx_busy,
  output logic               tx_ovf,
  input  logic               tx_ovf_clr,
  output logic [FIFO_AW:0]   tx_count,
  output logic               txd
);

  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [2:0]         bit_idx, bit_idx_d;
  logic [7:0]         shift, shift_d;
  logic               txd_d;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]      count_d;
  logic               have_data, full_now, bit_end, pop, wr_acc, ovf_d;

  // FIFO status on the pre-edge count
  assign have_data = (tx_count != '0);
  assign full_now  = (tx_count == CW'(FIFO_DEPTH));
  assign bit_end   = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign wr_acc    = tx_wr && !full_now;
  assign pop       = have_data && ((state == IDLE) || (state == STOP && bit_end));
  assign count_d   = tx_count + CW'(wr_acc) - CW'(pop);
  // a write while full sets the flag even if a pop frees a slot on the same edge
  assign ovf_d     = (tx_wr && full_now) ? 1'b1 : (tx_ovf_clr ? 1'b0 : tx_ovf);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (have_data) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && bit_idx == 3'd7) state_d = STOP;
      STOP:    if (bit_end) state_d = have_data ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; shift[0] always holds the bit on the line in DATA
  always_comb begin
    txd_d     = txd;
    shift_d   = shift;
    bit_idx_d = bit_idx;
    cnt_d     = bit_end ? '0 : cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        cnt_d = '0;
        txd_d = 1'b1;
        if (have_data) begin
          shift_d = mem[rd_ptr];
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = 3'd0;
          txd_d     = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            txd_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shift_d   = shift >> 1;
            txd_d     = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (have_data) begin
            shift_d = mem[rd_ptr];
            txd_d   = 1'b0;
          end else begin
            txd_d = 1'b1;
          end
        end
      end
      default: begin
        cnt_d = '0;
        txd_d = 1'b1;
      end
    endcase
  end

  // Datapath, FIFO control and registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txd      <= 1'b1;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_count <= '0;
      tx_ovf   <= 1'b0;
      tx_full  <= 1'b0;
      tx_empty <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      txd      <= txd_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_idx_d;
      shift    <= shift_d;
      if (wr_acc) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)    rd_ptr <= rd_ptr + FIFO_AW'(1);
      tx_count <= count_d;
      tx_ovf   <= ovf_d;
      tx_full  <= (count_d == CW'(FIFO_DEPTH));
      tx_empty <= (count_d == '0);
      tx_busy  <= (state_d != IDLE);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= tx_data;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-serial UART transmitter (8N1), the transmit-side counterpart of the SoC's uart receiver (u_uart.urx).
- Sits inside the uart block on the cpu_clk domain. The CPU data path writes bytes into a small FIFO, and the block serialises them onto txd, LSB first.
- Frames are sent back-to-back while the FIFO holds data. txd idles high.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 4, transmit FIFO entries; power of 2, >= 2.
- FIFO_AW, 2, FIFO address width; equals log2(FIFO_DEPTH).

Ports:
- clk  in  1  block clock.
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  byte to enqueue.
- tx_wr  in  1  write strobe; tx_data is sampled on the rising clk edge when tx_wr=1.
- tx_full  out  1  FIFO holds FIFO_DEPTH entries.
- tx_empty  out  1  FIFO holds 0 entries.
- tx_busy  out  1  state machine is not IDLE (a frame is on the line).
- tx_ovf  out  1  sticky overflow flag: a write arrived while full.
- tx_ovf_clr  in  1  clears tx_ovf on the next edge.
- tx_count  out  FIFO_AW+1  current FIFO occupancy.
- txd  out  1  serial output, registered.

Behaviour:
- Reset (async, active-high), applied immediately and held while reset=1:
  - txd=1, state=IDLE, FIFO pointers and tx_count=0.
  - tx_empty=1, tx_full=0, tx_busy=0, tx_ovf=0.
  - Baud counter=0, bit index=0.
  - Reset mid-frame aborts the frame: txd goes to 1 at once and queued bytes are discarded.
- FIFO:
  - Circular buffer with FIFO_AW-bit read/write pointers and a separate (FIFO_AW+1)-bit count.
  - Pointers wrap modulo FIFO_DEPTH.
  - Write accepted when tx_wr=1 and count<FIFO_DEPTH, judged on the pre-edge count.
  - A write while full is dropped and sets tx_ovf. This holds even if a pop occurs on the same edge.
  - Simultaneous accepted write and pop leave count unchanged.
  - tx_ovf set has priority over tx_ovf_clr on the same edge.
- State machine (one-hot or encoded; no other states):
  - IDLE: txd=1. If FIFO is non-empty, pop the head into the shift register, go to START, set txd=0, counter=0.
  - START: hold txd=0 for CLKS_PER_BIT cycles. Then go to DATA with bit index 0 and txd=shift[0].
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7 completes, go to STOP with txd=1.
  - STOP: hold txd=1 for CLKS_PER_BIT cycles. Then:
    - if the FIFO is non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1. The bit ends on the edge where counter==CLKS_PER_BIT-1; the counter then reloads to 0.
- Timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Latency: for a write sampled at edge N into an empty FIFO with state IDLE, the pop occurs and txd falls at edge N+1.
  - tx_empty deasserts after edge N and reasserts after edge N+1.
- tx_busy=1 in START, DATA and STOP.
- tx_data is not required stable after the sampling edge; the FIFO captures it.
- txd must never glitch; it is driven only from a flop.

Test Plan:
- Run all scenarios with CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted.
- Single byte: reset, then write 0x85 once.
  - txd, sampled mid-bit, is 0,1,0,1,0,0,0,0,1,1 (start, LSB..MSB, stop).
  - txd is low from edge N+1 for exactly 4 cycles; the total frame is 40 cycles.
  - tx_busy=0 after the frame.
- Back-to-back: write 0x85 then 0x7F on consecutive cycles.
  - The second start bit begins on the edge immediately after the first stop bit ends (80 cycles total, no gap).
  - 0x7F bits are 1,1,1,1,1,1,1,0.
- Full/overflow: with the line busy, write 0x01..0x05 on five consecutive cycles.
  - The first byte pops immediately. 0x02..0x05 fill the FIFO and tx_full=1 after the 5th edge, so no byte is dropped.
  - A 6th write of 0xAA is dropped and tx_ovf=1.
  - Pulsing tx_ovf_clr clears tx_ovf.
  - The output sequence is 0x01..0x05.
- Pointer wrap: send 10 bytes (0x10..0x19) over time, keeping occupancy ≤ 3. All arrive in order and tx_count returns to 0.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued.
  - txd=1 and tx_empty=1 immediately.
  - After release, no frame is transmitted without a new write.
- Simultaneous write and pop: at the STOP-end edge, write 0x33 while 1 entry is queued. tx_count stays 1 and both bytes are sent in order.
